// File: rtl/cam_search_sched.sv
// cam_search_sched
// Schedules field-extraction requesters onto the single search port of the
// message CAM. A round-robin arbiter picks one requester at a time, the
// search is confined to the current message window, and the CAM result (or
// a timeout error) is returned to the requester that was granted.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   store_start_i/_addr   latch window start (invalidates the window)
//   store_end_i/_addr     latch window end (validates the window)
//   req_i, req_data_i     per-requester search request level and key
//   resp_valid_o          one-hot response pulse to the granted requester
//   resp_hit_o/_index_o   shared search result, valid with resp_valid_o
//   resp_err_o            shared timeout flag, valid with resp_valid_o
//   busy_o                a search is in progress
//   window_valid_o        a complete window (start and end) is held
//   cam_start_o/_end_o    window snapshot presented to the CAM
//   cam_search_o/_data_o  one-cycle search strobe and key to the CAM
//   cam_search_done_i     CAM result pulse with valid/index
module cam_search_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          store_start_i,
  input  logic [ADDR_WIDTH-1:0]         start_addr_i,
  input  logic                          store_end_i,
  input  logic [ADDR_WIDTH-1:0]         end_addr_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            resp_valid_o,
  output logic                          resp_hit_o,
  output logic [ADDR_WIDTH-1:0]         resp_index_o,
  output logic                          resp_err_o,
  output logic                          busy_o,
  output logic                          window_valid_o,
  output logic [ADDR_WIDTH-1:0]         cam_start_o,
  output logic [ADDR_WIDTH-1:0]         cam_end_o,
  output logic                          cam_search_o,
  output logic [DATA_WIDTH-1:0]         cam_search_data_o,
  input  logic                          cam_search_done_i,
  input  logic                          cam_search_valid_i,
  input  logic [ADDR_WIDTH-1:0]         cam_search_index_i
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                  state;
  logic [PTR_W-1:0]        rr_ptr;
  logic [PTR_W-1:0]        grantee;
  logic [CNT_W-1:0]        cnt;
  logic [ADDR_WIDTH-1:0]   win_start;
  logic [ADDR_WIDTH-1:0]   win_end;
  logic                    window_valid;

  logic                    grant_found;
  logic [PTR_W-1:0]        grant_idx;
  logic [PTR_W-1:0]        next_ptr;
  logic [DATA_WIDTH-1:0]   keys [NUM_REQ];

  // Unpack the flat key bus into one entry per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_keys
    assign keys[gi] = req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin pick: scan offsets from the highest down so the smallest
  // offset from rr_ptr with an active request is the one that sticks.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      logic [PTR_W-1:0] cand;
      cand = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (req_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    next_ptr = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + PTR_W'(1);
  end

  // Message window registers. A start store alone opens a new, incomplete
  // window; an end store completes it (and wins if both arrive together).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_start    <= '0;
      win_end      <= '0;
      window_valid <= 1'b0;
    end else begin
      if (store_start_i) begin
        win_start <= start_addr_i;
      end
      if (store_end_i) begin
        win_end <= end_addr_i;
      end
      if (store_end_i) begin
        window_valid <= 1'b1;
      end else if (store_start_i) begin
        window_valid <= 1'b0;
      end
    end
  end

  assign window_valid_o = window_valid;

  // Search FSM with registered outputs. The strobe and response pulses are
  // set on the transition into ISSUE/RESP and default back to zero, so each
  // lasts exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      rr_ptr            <= '0;
      grantee           <= '0;
      cnt               <= '0;
      resp_valid_o      <= '0;
      resp_hit_o        <= 1'b0;
      resp_index_o      <= '0;
      resp_err_o        <= 1'b0;
      busy_o            <= 1'b0;
      cam_start_o       <= '0;
      cam_end_o         <= '0;
      cam_search_o      <= 1'b0;
      cam_search_data_o <= '0;
    end else begin
      cam_search_o <= 1'b0;
      resp_valid_o <= '0;
      unique case (state)
        IDLE: begin
          if (window_valid && grant_found) begin
            grantee           <= grant_idx;
            rr_ptr            <= next_ptr;
            // Window is frozen here; later stores only affect the next grant.
            cam_start_o       <= win_start;
            cam_end_o         <= win_end;
            cam_search_data_o <= keys[grant_idx];
            cam_search_o      <= 1'b1;
            busy_o            <= 1'b1;
            state             <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A done arriving on the timeout cycle still counts as a result.
          if (cam_search_done_i) begin
            resp_hit_o            <= cam_search_valid_i;
            resp_index_o          <= cam_search_valid_i ? cam_search_index_i : '0;
            resp_err_o            <= 1'b0;
            resp_valid_o[grantee] <= 1'b1;
            state                 <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            resp_hit_o            <= 1'b0;
            resp_index_o          <= '0;
            resp_err_o            <= 1'b1;
            resp_valid_o[grantee] <= 1'b1;
            state                 <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          resp_hit_o   <= 1'b0;
          resp_index_o <= '0;
          resp_err_o   <= 1'b0;
          busy_o       <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_search_sched.sv
module tb_cam_search_sched;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             store_start_i, store_end_i;
  logic [AW-1:0]    start_addr_i, end_addr_i;
  logic [NR-1:0]    req_i;
  logic [NR*DW-1:0] req_data_i;
  logic [NR-1:0]    resp_valid_o;
  logic             resp_hit_o, resp_err_o, busy_o, window_valid_o;
  logic [AW-1:0]    resp_index_o, cam_start_o, cam_end_o;
  logic             cam_search_o;
  logic [DW-1:0]    cam_search_data_o;
  logic             cam_search_done_i, cam_search_valid_i;
  logic [AW-1:0]    cam_search_index_i;

  always #5 clk = ~clk;

  cam_search_sched #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .store_start_i(store_start_i), .start_addr_i(start_addr_i),
    .store_end_i(store_end_i), .end_addr_i(end_addr_i),
    .req_i(req_i), .req_data_i(req_data_i),
    .resp_valid_o(resp_valid_o), .resp_hit_o(resp_hit_o),
    .resp_index_o(resp_index_o), .resp_err_o(resp_err_o),
    .busy_o(busy_o), .window_valid_o(window_valid_o),
    .cam_start_o(cam_start_o), .cam_end_o(cam_end_o),
    .cam_search_o(cam_search_o), .cam_search_data_o(cam_search_data_o),
    .cam_search_done_i(cam_search_done_i), .cam_search_valid_i(cam_search_valid_i),
    .cam_search_index_i(cam_search_index_i)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Reference model state: window and round-robin pointer, by the rules.
  int            m_rr;
  logic [AW-1:0] m_start, m_end;
  bit            m_valid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  function automatic int rr_pick(input logic [NR-1:0] r, input int p);
    for (int i = 0; i < NR; i++) begin
      if (r[(p + i) % NR]) return (p + i) % NR;
    end
    return -1;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_resp_valid"}, 64'(resp_valid_o), 64'(0));
    chk({tag, "_hit"}, 64'(resp_hit_o), 64'(0));
    chk({tag, "_index"}, 64'(resp_index_o), 64'(0));
    chk({tag, "_err"}, 64'(resp_err_o), 64'(0));
    chk({tag, "_busy"}, 64'(busy_o), 64'(0));
    chk({tag, "_win_valid"}, 64'(window_valid_o), 64'(0));
    chk({tag, "_cam_start"}, 64'(cam_start_o), 64'(0));
    chk({tag, "_cam_end"}, 64'(cam_end_o), 64'(0));
    chk({tag, "_strobe"}, 64'(cam_search_o), 64'(0));
    chk({tag, "_data"}, 64'(cam_search_data_o), 64'(0));
  endtask

  task automatic store_win(input bit do_s, input int s, input bit do_e, input int e);
    store_start_i = do_s; start_addr_i = AW'(s);
    store_end_i   = do_e; end_addr_i   = AW'(e);
    if (do_s) begin m_start = AW'(s); m_valid = 1'b0; end
    if (do_e) begin m_end = AW'(e); m_valid = 1'b1; end
    tick();
    store_start_i = 1'b0;
    store_end_i   = 1'b0;
  endtask

  // One complete search. d>0: CAM done d cycles after the strobe; d<0: never.
  // poke>=0 stores a new window start in the first WAIT cycle.
  task automatic do_search(input int d, input bit v, input logic [AW-1:0] ix, input int poke,
                           output int g, output int wait_n, output int resp_cyc);
    logic [AW-1:0] xs, xe;
    logic [DW-1:0] xk;
    int n;
    g = rr_pick(req_i, m_rr);
    resp_cyc = -1;
    n = 0;
    while (cam_search_o !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    wait_n = n;
    chk("strobe_seen", 64'(cam_search_o), 64'(1));
    if (cam_search_o !== 1'b1 || g < 0) return;
    xs = m_start;
    xe = m_end;
    xk = req_data_i[g*DW +: DW];
    chk("cam_start", 64'(cam_start_o), 64'(xs));
    chk("cam_end", 64'(cam_end_o), 64'(xe));
    chk("cam_key", 64'(cam_search_data_o), 64'(xk));
    chk("busy_issue", 64'(busy_o), 64'(1));
    if (poke >= 0) begin
      store_start_i = 1'b1;
      start_addr_i  = AW'(poke);
      m_start = AW'(poke);
      m_valid = 1'b0;
    end
    if (d > 0) begin
      for (int j = 1; j <= d; j++) begin
        tick();
        store_start_i = 1'b0;
        chk("single_strobe", 64'(cam_search_o), 64'(0));
        chk("no_early_resp", 64'(resp_valid_o), 64'(0));
        chk("frozen_start", 64'(cam_start_o), 64'(xs));
        chk("frozen_end", 64'(cam_end_o), 64'(xe));
        if (j == d) begin
          cam_search_done_i = 1'b1; cam_search_valid_i = v; cam_search_index_i = ix;
        end
      end
      tick();
      cam_search_done_i = 1'b0; cam_search_valid_i = 1'b0; cam_search_index_i = '0;
      chk("resp_valid", 64'(resp_valid_o), 64'(1) << g);
      chk("resp_hit", 64'(resp_hit_o), 64'(v));
      chk("resp_index", 64'(resp_index_o), v ? 64'(ix) : 64'(0));
      chk("resp_err", 64'(resp_err_o), 64'(0));
    end else begin
      for (int j = 1; j <= TO + 2; j++) begin
        tick();
        store_start_i = 1'b0;
        if (j < TO + 2) chk("no_early_resp", 64'(resp_valid_o), 64'(0));
      end
      chk("to_resp_valid", 64'(resp_valid_o), 64'(1) << g);
      chk("to_hit", 64'(resp_hit_o), 64'(0));
      chk("to_index", 64'(resp_index_o), 64'(0));
      chk("to_err", 64'(resp_err_o), 64'(1));
    end
    chk("resp_frozen_start", 64'(cam_start_o), 64'(xs));
    chk("busy_resp", 64'(busy_o), 64'(1));
    resp_cyc = cyc;
    m_rr = (g + 1) % NR;
    $display("[TB] search grantee=%0d key=0x%08h start=%0d end=%0d delay=%0d -> valid=%b hit=%b idx=%0d err=%b",
             g, xk, xs, xe, d, resp_valid_o, resp_hit_o, resp_index_o, resp_err_o);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, n, rc, prev;
    rst = 1'b1;
    store_start_i = 1'b0; store_end_i = 1'b0; start_addr_i = '0; end_addr_i = '0;
    req_i = '0; req_data_i = '0;
    cam_search_done_i = 1'b0; cam_search_valid_i = 1'b0; cam_search_index_i = '0;
    m_rr = 0; m_start = '0; m_end = '0; m_valid = 1'b0;

    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    // Request with no window: nothing happens until the end address is stored.
    req_data_i[1*DW +: DW] = 32'h38333D35;
    req_i = 4'b0010;
    repeat (4) begin
      tick();
      chk("nowin_strobe", 64'(cam_search_o), 64'(0));
      chk("nowin_busy", 64'(busy_o), 64'(0));
    end
    store_win(1, 3, 0, 0);
    chk("start_only_invalid", 64'(window_valid_o), 64'(0));
    store_win(0, 0, 1, 9);
    chk("end_makes_valid", 64'(window_valid_o), 64'(1));
    chk("no_strobe_yet", 64'(cam_search_o), 64'(0));
    do_search(2, 1'b1, 5'd5, -1, g, n, rc);
    chk("strobe_after_store", 64'(n), 64'(1));

    // Requester 0 with the reference key, window 3..9.
    req_data_i[0*DW +: DW] = 32'h38333D35;
    req_i = 4'b0001;
    do_search(2, 1'b1, 5'd5, -1, g, n, rc);
    chk("req0_latency", 64'(n), 64'(2));

    // All four requesting continuously; CAM answers in the first WAIT cycle.
    req_i = 4'b1111;
    for (int r = 0; r < NR; r++) req_data_i[r*DW +: DW] = $urandom;
    prev = -1;
    for (int k = 0; k < 5; k++) begin
      do_search(1, 1'($urandom_range(0, 1)), AW'($urandom), -1, g, n, rc);
      if (k > 0) chk("rr_spacing", 64'(rc - prev), 64'(4));
      prev = rc;
    end

    // Timeout, then a done exactly on the timeout cycle, then a miss.
    req_i = 4'b0100;
    do_search(-1, 1'b0, '0, -1, g, n, rc);
    do_search(TO + 1, 1'b1, 5'd7, -1, g, n, rc);
    do_search(3, 1'b0, 5'd9, -1, g, n, rc);

    // Wrapped window; new start stored mid-search.
    req_i = 4'b0000;
    tick();
    tick();
    store_win(1, 28, 1, 2);
    chk("both_store_valid", 64'(window_valid_o), 64'(1));
    req_data_i[3*DW +: DW] = $urandom;
    req_i = 4'b1000;
    do_search(3, 1'b1, 5'd30, 10, g, n, rc);
    chk("poke_invalidates", 64'(window_valid_o), 64'(0));
    repeat (5) begin
      tick();
      chk("held_no_strobe", 64'(cam_search_o), 64'(0));
      chk("held_not_busy", 64'(busy_o), 64'(0));
    end
    store_win(0, 0, 1, 20);
    do_search(2, 1'b1, 5'd12, -1, g, n, rc);
    chk("restore_latency", 64'(n), 64'(1));

    // Randomised traffic against the model.
    for (int k = 0; k < 20; k++) begin
      req_i = NR'($urandom_range(1, 15));
      for (int r = 0; r < NR; r++) req_data_i[r*DW +: DW] = $urandom;
      do_search($urandom_range(1, 6), 1'($urandom_range(0, 1)), AW'($urandom), -1, g, n, rc);
    end

    // Reset in the middle of a search; a late done must be ignored.
    req_i = 4'b0001;
    n = 0;
    while (cam_search_o !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    chk("rst_test_strobe", 64'(cam_search_o), 64'(1));
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk_zero("rst_mid");
    m_rr = 0; m_start = '0; m_end = '0; m_valid = 1'b0;
    tick();
    rst = 1'b0;
    cam_search_done_i = 1'b1; cam_search_valid_i = 1'b1; cam_search_index_i = 5'd3;
    tick();
    cam_search_done_i = 1'b0; cam_search_valid_i = 1'b0; cam_search_index_i = '0;
    repeat (6) begin
      tick();
      chk("post_rst_no_resp", 64'(resp_valid_o), 64'(0));
      chk("post_rst_no_strobe", 64'(cam_search_o), 64'(0));
      chk("post_rst_idle", 64'(busy_o), 64'(0));
    end
    req_i = 4'b0110;
    for (int r = 0; r < NR; r++) req_data_i[r*DW +: DW] = $urandom;
    store_win(1, 4, 1, 7);
    do_search(1, 1'b1, 5'd6, -1, g, n, rc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
